store_buffer_drain: RTL and testbench

Parametrised in-order store buffer sitting between issue/execute and the data-memory port, successor to the single-pointer store buffer. Tracks three pointers (allocate, ROB-commit, memory-drain), so stores retired by the ROB survive a mispredict flush and drain to memory under a valid/ready handshake. Supports byte-enabled sub-word stores and byte-accurate store-to-load forwarding with stall signalling for partial or unknown-address overlaps.

---
 rtl/store_buffer_drain_if.sv | 53 +++++
 rtl/store_buffer_drain.sv | 165 ++++++++++++++++
 tb/tb_store_buffer_drain.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_drain_if.sv
// Handshake/bus bundle for store_buffer_drain: allocate, writeback, commit/flush,
// memory drain and load-forwarding lookup channels.
interface store_buffer_drain_if #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BYTES = DATA_W / 8;
  localparam int IW    = $clog2(DEPTH) + 1;

  logic              alloc_v_i;
  logic              alloc_ready_o;
  logic [IW-1:0]     alloc_idx_o;
  logic              wb_v_i;
  logic [IW-1:0]     wb_idx_i;
  logic [ADDR_W-1:0] wb_addr_i;
  logic [DATA_W-1:0] wb_data_i;
  logic [BYTES-1:0]  wb_be_i;
  logic              rob_commit_v_i;
  logic              commit_ready_o;
  logic              rob_flush_i;
  logic              mem_v_o;
  logic              mem_ready_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [BYTES-1:0]  mem_be_o;
  logic              ld_v_i;
  logic [ADDR_W-1:0] ld_addr_i;
  logic [BYTES-1:0]  ld_be_i;
  logic [IW-1:0]     ld_age_idx_i;
  logic              ld_hit_o;
  logic [DATA_W-1:0] ld_data_o;
  logic              ld_stall_o;
  logic              empty_o;

  modport slave (
    input  alloc_v_i, wb_v_i, wb_idx_i, wb_addr_i, wb_data_i, wb_be_i,
           rob_commit_v_i, rob_flush_i, mem_ready_i,
           ld_v_i, ld_addr_i, ld_be_i, ld_age_idx_i,
    output alloc_ready_o, alloc_idx_o, commit_ready_o,
           mem_v_o, mem_addr_o, mem_data_o, mem_be_o,
           ld_hit_o, ld_data_o, ld_stall_o, empty_o
  );

  modport master (
    output alloc_v_i, wb_v_i, wb_idx_i, wb_addr_i, wb_data_i, wb_be_i,
           rob_commit_v_i, rob_flush_i, mem_ready_i,
           ld_v_i, ld_addr_i, ld_be_i, ld_age_idx_i,
    input  alloc_ready_o, alloc_idx_o, commit_ready_o,
           mem_v_o, mem_addr_o, mem_data_o, mem_be_o,
           ld_hit_o, ld_data_o, ld_stall_o, empty_o
  );
endinterface

// File: rtl/store_buffer_drain.sv
// In-order store buffer with allocate/commit/drain pointers, flush recovery of
// committed stores and byte-accurate store-to-load forwarding.
module store_buffer_drain #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                 clk_i,
  input logic                 reset_n_i,
  store_buffer_drain_if.slave sb
);
  localparam int BYTES = DATA_W / 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int IW    = AW + 1;
  localparam int OFF   = $clog2(BYTES);

  typedef logic [IW-1:0] ptr_t;
  typedef logic [AW-1:0] idx_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BYTES-1:0]  be;
  } ent_t;

  ptr_t alloc_q, alloc_d, commit_q, commit_d, drain_q, drain_d;
  logic [DEPTH-1:0] wb_q, wb_d;
  ent_t [DEPTH-1:0] ent_q, ent_d;

  ptr_t count, ucnt, wb_off, age_off, win;
  logic full, commit_ready, mem_v;
  logic alloc_fire, commit_fire, drain_fire, wb_fire;
  idx_t alloc_ix, commit_ix, drain_ix, wb_ix;

  assign alloc_ix  = alloc_q[AW-1:0];
  assign commit_ix = commit_q[AW-1:0];
  assign drain_ix  = drain_q[AW-1:0];
  assign wb_ix     = sb.wb_idx_i[AW-1:0];

  assign count   = alloc_q - drain_q;
  assign ucnt    = alloc_q - commit_q;
  assign full    = (count == ptr_t'(DEPTH));
  assign wb_off  = sb.wb_idx_i - commit_q;
  assign age_off = sb.ld_age_idx_i - drain_q;
  // A stale age tag (outside [drain, alloc]) collapses the window to nothing.
  assign win     = (age_off <= count) ? age_off : '0;

  assign commit_ready = (commit_q != alloc_q) && wb_q[commit_ix];
  assign mem_v        = (drain_q != commit_q);

  assign alloc_fire  = sb.alloc_v_i && !full && !sb.rob_flush_i;
  assign commit_fire = sb.rob_commit_v_i && commit_ready;
  assign drain_fire  = mem_v && sb.mem_ready_i;
  assign wb_fire     = sb.wb_v_i && !sb.rob_flush_i && (wb_off < ucnt);

  assign sb.alloc_ready_o  = !full && !sb.rob_flush_i;
  assign sb.alloc_idx_o    = alloc_q;
  assign sb.commit_ready_o = commit_ready;
  assign sb.mem_v_o        = mem_v;
  assign sb.mem_addr_o     = mem_v ? ent_q[drain_ix].addr : '0;
  assign sb.mem_data_o     = mem_v ? ent_q[drain_ix].data : '0;
  assign sb.mem_be_o       = mem_v ? ent_q[drain_ix].be   : '0;
  assign sb.empty_o        = (count == '0);

  // Next-state: the three legal slices never overlap, so update order is free.
  idx_t fl_off;
  always_comb begin
    alloc_d  = alloc_q;
    commit_d = commit_q;
    drain_d  = drain_q;
    wb_d     = wb_q;
    ent_d    = ent_q;
    fl_off   = '0;
    if (wb_fire) begin
      wb_d[wb_ix]       = 1'b1;
      ent_d[wb_ix].addr = sb.wb_addr_i;
      ent_d[wb_ix].data = sb.wb_data_i;
      ent_d[wb_ix].be   = sb.wb_be_i;
    end
    if (commit_fire) commit_d = commit_q + ptr_t'(1);
    if (drain_fire) begin
      wb_d[drain_ix] = 1'b0;
      drain_d        = drain_q + ptr_t'(1);
    end
    if (alloc_fire) begin
      wb_d[alloc_ix] = 1'b0;
      alloc_d        = alloc_q + ptr_t'(1);
    end
    if (sb.rob_flush_i) begin
      alloc_d = commit_d;
      for (int i = 0; i < DEPTH; i++) begin
        fl_off = idx_t'(i) - commit_d[AW-1:0];
        if ({1'b0, fl_off} < (alloc_q - commit_d)) wb_d[i] = 1'b0;
      end
    end
  end

  // Forwarding scan runs oldest to youngest so the last match is the youngest.
  logic             fwd_unk, fwd_sel;
  logic [BYTES-1:0] sel_be;
  logic [DATA_W-1:0] sel_data;
  idx_t             fidx;
  always_comb begin
    fwd_unk  = 1'b0;
    fwd_sel  = 1'b0;
    sel_be   = '0;
    sel_data = '0;
    fidx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fidx = drain_ix + idx_t'(k);
      if (ptr_t'(k) < win) begin
        if (!wb_q[fidx]) begin
          fwd_unk = 1'b1;
        end else if (ent_q[fidx].addr[ADDR_W-1:OFF] == sb.ld_addr_i[ADDR_W-1:OFF]) begin
          fwd_sel  = 1'b1;
          sel_be   = ent_q[fidx].be;
          sel_data = ent_q[fidx].data;
        end
      end
    end
  end

  logic              ld_hit, ld_stall;
  logic [DATA_W-1:0] ld_data;
  always_comb begin
    ld_hit   = 1'b0;
    ld_stall = 1'b0;
    ld_data  = '0;
    if (sb.ld_v_i && !sb.rob_flush_i) begin
      if (fwd_unk) begin
        ld_stall = 1'b1;
      end else if (fwd_sel) begin
        if ((sel_be & sb.ld_be_i) == sb.ld_be_i) begin
          ld_hit = 1'b1;
          for (int b = 0; b < BYTES; b++)
            ld_data[b*8 +: 8] = sel_be[b] ? sel_data[b*8 +: 8] : 8'h00;
        end else begin
          ld_stall = 1'b1;
        end
      end
    end
  end

  assign sb.ld_hit_o   = ld_hit;
  assign sb.ld_stall_o = ld_stall;
  assign sb.ld_data_o  = ld_data;

  logic unused_ld_lo;
  assign unused_ld_lo = ^sb.ld_addr_i[OFF-1:0];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      alloc_q  <= '0;
      commit_q <= '0;
      drain_q  <= '0;
      wb_q     <= '0;
      ent_q    <= '0;
    end else begin
      alloc_q  <= alloc_d;
      commit_q <= commit_d;
      drain_q  <= drain_d;
      wb_q     <= wb_d;
      ent_q    <= ent_d;
    end
  end
endmodule

// File: tb/tb_store_buffer_drain.sv
// Directed + random bench for store_buffer_drain against a sequence-number
// model of the store stream (unbounded alloc/commit/drain counters).
module tb_store_buffer_drain;
  localparam int DEPTH = 4, ADDR_W = 32, DATA_W = 32, M = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_buffer_drain_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();
  store_buffer_drain #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .sb(bus));

  int total = 0;
  int bad = 0;
  int an, cn, dn;
  logic        m_wb  [0:4095];
  logic [31:0] m_addr[0:4095];
  logic [31:0] m_data[0:4095];
  logic [3:0]  m_be  [0:4095];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    an = 0; cn = 0; dn = 0;
    for (int n = 0; n < 4096; n++) m_wb[n] = 1'b0;
  endtask

  function automatic int age_seq(input logic [2:0] tag);
    for (int n = dn; n <= an; n++) if ((n % M) == int'(tag)) return n;
    return -1;
  endfunction

  task automatic check_all();
    logic e_hit, e_stall, unk, mv;
    logic [31:0] e_ld;
    int s, found;
    mv = (dn < cn);
    chk("alloc_ready", bus.alloc_ready_o, (an - dn < DEPTH) && !bus.rob_flush_i);
    chk("alloc_idx",   bus.alloc_idx_o, an % M);
    chk("commit_ready", bus.commit_ready_o, (cn < an) && m_wb[cn]);
    chk("mem_v",    bus.mem_v_o, mv);
    chk("mem_addr", bus.mem_addr_o, mv ? m_addr[dn] : 32'h0);
    chk("mem_data", bus.mem_data_o, mv ? m_data[dn] : 32'h0);
    chk("mem_be",   bus.mem_be_o, mv ? m_be[dn] : 4'h0);
    chk("empty",    bus.empty_o, an == dn);
    e_hit = 0; e_stall = 0; e_ld = 0;
    if (bus.ld_v_i && !bus.rob_flush_i) begin
      s = age_seq(bus.ld_age_idx_i);
      if (s >= 0) begin
        unk = 0;
        for (int n = dn; n < s; n++) if (!m_wb[n]) unk = 1;
        if (unk) e_stall = 1;
        else begin
          found = -1;
          for (int n = s - 1; n >= dn; n--)
            if (found < 0 && m_addr[n][31:2] == bus.ld_addr_i[31:2]) found = n;
          if (found >= 0) begin
            if ((m_be[found] & bus.ld_be_i) == bus.ld_be_i) begin
              e_hit = 1;
              for (int b = 0; b < 4; b++)
                if (m_be[found][b]) e_ld[b*8 +: 8] = m_data[found][b*8 +: 8];
            end else e_stall = 1;
          end
        end
      end
    end
    chk("ld_hit",   bus.ld_hit_o, e_hit);
    chk("ld_stall", bus.ld_stall_o, e_stall);
    chk("ld_data",  bus.ld_data_o, e_ld);
  endtask

  // One clock: check outputs against the model, then advance the model.
  task automatic cyc();
    logic cr, mv, ar;
    int s;
    #1 check_all();
    cr = (cn < an) && m_wb[cn];
    mv = (dn < cn);
    ar = (an - dn < DEPTH) && !bus.rob_flush_i;
    @(posedge clk);
    if (bus.wb_v_i && !bus.rob_flush_i) begin
      s = -1;
      for (int n = cn; n < an; n++) if ((n % M) == int'(bus.wb_idx_i)) s = n;
      if (s >= 0) begin
        m_wb[s] = 1; m_addr[s] = bus.wb_addr_i; m_data[s] = bus.wb_data_i; m_be[s] = bus.wb_be_i;
      end
    end
    if (bus.rob_commit_v_i && cr) cn++;
    if (mv && bus.mem_ready_i) dn++;
    if (bus.alloc_v_i && ar) begin m_wb[an] = 0; an++; end
    if (bus.rob_flush_i) begin
      for (int n = cn; n < an; n++) m_wb[n] = 0;
      an = cn;
    end
    @(negedge clk);
  endtask

  task automatic clr();
    bus.alloc_v_i = 0; bus.wb_v_i = 0; bus.wb_idx_i = 0; bus.wb_addr_i = 0;
    bus.wb_data_i = 0; bus.wb_be_i = 0; bus.rob_commit_v_i = 0; bus.rob_flush_i = 0;
    bus.mem_ready_i = 0; bus.ld_v_i = 0; bus.ld_addr_i = 0; bus.ld_be_i = 0;
    bus.ld_age_idx_i = 0;
  endtask

  task automatic do_alloc(output logic [2:0] idx);
    idx = 3'(an % M);
    bus.alloc_v_i = 1; cyc(); bus.alloc_v_i = 0;
  endtask

  task automatic do_wb(input logic [2:0] idx, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be);
    bus.wb_v_i = 1; bus.wb_idx_i = idx; bus.wb_addr_i = a; bus.wb_data_i = d; bus.wb_be_i = be;
    cyc(); bus.wb_v_i = 0;
  endtask

  task automatic do_commit();
    bus.rob_commit_v_i = 1; cyc(); bus.rob_commit_v_i = 0;
  endtask

  logic [2:0] i0, i1, i2;
  int span;

  initial begin
    clr();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_alloc_ready", bus.alloc_ready_o, 1);
    chk("rst_alloc_idx", bus.alloc_idx_o, 0);
    chk("rst_mem_v", bus.mem_v_o, 0);
    chk("rst_empty", bus.empty_o, 1);
    cyc();

    // Fill to DEPTH, then free one slot and observe the wrap bit.
    for (int i = 0; i < DEPTH; i++) begin
      bus.alloc_v_i = 1;
      #1 chk("fill_idx", bus.alloc_idx_o, i);
      cyc();
    end
    clr();
    #1 chk("full_ready", bus.alloc_ready_o, 0);
    do_wb(0, 32'h10, 32'h1234, 4'hF);
    do_commit();
    bus.mem_ready_i = 1; cyc(); bus.mem_ready_i = 0;
    #1 chk("wrap_ready", bus.alloc_ready_o, 1);
    chk("wrap_idx", bus.alloc_idx_o, 4);
    bus.rob_flush_i = 1; cyc(); clr();

    // Back-pressured drain holds fields stable.
    do_alloc(i0);
    do_wb(i0, 32'h100, 32'hAABBCCDD, 4'hF);
    do_commit();
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_v", bus.mem_v_o, 1);
      chk("hold_addr", bus.mem_addr_o, 32'h100);
      chk("hold_data", bus.mem_data_o, 32'hAABBCCDD);
      chk("hold_be", bus.mem_be_o, 4'hF);
      cyc();
    end
    bus.mem_ready_i = 1; cyc(); bus.mem_ready_i = 0;
    #1 chk("drain_empty", bus.empty_o, 1);

    // Flush keeps committed stores, drops the speculative one.
    do_alloc(i0); do_alloc(i1); do_alloc(i2);
    do_wb(i0, 32'h300, 32'h3, 4'hF);
    do_wb(i1, 32'h304, 32'h4, 4'hF);
    do_wb(i2, 32'h308, 32'h5, 4'hF);
    do_commit(); do_commit();
    bus.rob_flush_i = 1; cyc(); bus.rob_flush_i = 0;
    #1 chk("flush_idx", bus.alloc_idx_o, i2);
    bus.mem_ready_i = 1;
    #1 chk("flush_drain0", bus.mem_addr_o, 32'h300);
    cyc();
    #1 chk("flush_drain1", bus.mem_addr_o, 32'h304);
    cyc();
    bus.mem_ready_i = 0;
    #1 chk("flush_empty", bus.empty_o, 1);

    // Youngest-match forwarding and partial-overlap stall.
    do_alloc(i0); do_alloc(i1);
    do_wb(i0, 32'h200, 32'h11111111, 4'hF);
    do_wb(i1, 32'h200, 32'h00000022, 4'h1);
    bus.ld_v_i = 1; bus.ld_addr_i = 32'h200; bus.ld_be_i = 4'h1; bus.ld_age_idx_i = 3'(an % M);
    #1 chk("fwd_hit", bus.ld_hit_o, 1);
    chk("fwd_data", bus.ld_data_o, 32'h22);
    cyc();
    bus.ld_be_i = 4'hF;
    #1 chk("fwd_partial_stall", bus.ld_stall_o, 1);
    chk("fwd_partial_hit", bus.ld_hit_o, 0);
    cyc(); clr();
    do_commit(); do_commit();
    bus.mem_ready_i = 1; cyc(); cyc(); bus.mem_ready_i = 0;

    // Unknown older address stalls any load until written back.
    do_alloc(i0);
    bus.ld_v_i = 1; bus.ld_addr_i = 32'h500; bus.ld_be_i = 4'hF; bus.ld_age_idx_i = 3'(an % M);
    #1 chk("unk_stall", bus.ld_stall_o, 1);
    cyc();
    bus.ld_v_i = 0;
    do_wb(i0, 32'h400, 32'h77, 4'hF);
    bus.ld_v_i = 1;
    #1 chk("known_stall", bus.ld_stall_o, 0);
    chk("known_hit", bus.ld_hit_o, 0);
    cyc(); clr();
    do_commit();
    bus.mem_ready_i = 1; cyc(); bus.mem_ready_i = 0;

    // Commit and flush in the same cycle.
    do_alloc(i0);
    do_wb(i0, 32'h600, 32'h66, 4'hF);
    do_alloc(i1);
    bus.rob_commit_v_i = 1; bus.rob_flush_i = 1; cyc(); clr();
    #1 chk("cf_mem_v", bus.mem_v_o, 1);
    chk("cf_addr", bus.mem_addr_o, 32'h600);
    chk("cf_idx", bus.alloc_idx_o, 3'(i0 + 3'd1));
    bus.mem_ready_i = 1; cyc(); bus.mem_ready_i = 0;

    // Asynchronous reset while a drain is pending.
    do_alloc(i0);
    do_wb(i0, 32'h700, 32'h99, 4'hF);
    do_commit();
    #1 chk("pre_rst_v", bus.mem_v_o, 1);
    #1 rst_n = 0;
    #1 chk("async_rst_v", bus.mem_v_o, 0);
    chk("async_rst_empty", bus.empty_o, 1);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    cyc();

    // Random traffic against the model.
    for (int t = 0; t < 600; t++) begin
      span = an - cn;
      bus.alloc_v_i = 1'($urandom_range(0, 1));
      bus.wb_v_i = ($urandom_range(0, 3) != 0);
      bus.wb_idx_i = ($urandom_range(0, 4) == 0) ? 3'($urandom) :
                     3'((cn + $urandom_range(0, (span > 0) ? span - 1 : 0)) % M);
      bus.wb_addr_i = 32'h100 + 32'($urandom_range(0, 2) * 4) + 32'($urandom_range(0, 3));
      bus.wb_data_i = $urandom;
      bus.wb_be_i = 4'($urandom);
      bus.rob_commit_v_i = 1'($urandom_range(0, 1));
      bus.rob_flush_i = ($urandom_range(0, 19) == 0);
      bus.mem_ready_i = 1'($urandom_range(0, 1));
      bus.ld_v_i = 1'($urandom_range(0, 1));
      bus.ld_addr_i = 32'h100 + 32'($urandom_range(0, 3) * 4);
      bus.ld_be_i = 4'($urandom);
      bus.ld_age_idx_i = ($urandom_range(0, 4) == 0) ? 3'($urandom) :
                         3'((dn + $urandom_range(0, an - dn)) % M);
      cyc();
    end
    clr();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
